// File: rtl/ram_bus_ctrl_pkg.sv
// ram_bus_ctrl_pkg
//   Shared types for the RAM bus controller:
//   - state_t : bus sequencer FSM encoding (IDLE, ADDR, STROBE, HOLD)
//   - req_t   : one queued access {we, addr, wdata}
//   - REQ_W   : packed width of req_t, used to size the request queue
package ram_bus_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/ram_req_fifo.sv
// ram_req_fifo
//   Synchronous FIFO holding pending RAM requests.
//   Ports:
//     clk, rst_n   : clock, async active-low reset (empties the queue)
//     push, wdata  : enqueue; ignored while full (even with a same-cycle pop)
//     pop          : dequeue head; ignored while empty
//     rdata        : current head entry
//     full, empty  : occupancy flags
module ram_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == FULL_CNT);
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign rdata  = r_mem[r_rptr];

    // Storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wdata;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl
//   Queues RAM accesses and plays them onto a simple async-RAM bus one at a
//   time, in acceptance order.
//   Ports:
//     clk, rst_n                         : clock, async active-low reset
//     req_valid/req_ready                : request handshake
//     req_we, req_addr, req_wdata        : request payload
//     rsp_valid, rsp_data                : one-cycle read response
//     A, Dd, wr                          : RAM address, write data, strobe
//     D                                  : RAM combinational read data
//     busy                               : work queued or in flight
module ram_bus_ctrl
    import ram_bus_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] Dd,
    output logic              wr,
    input  logic [DATA_W-1:0] D,
    output logic              busy
);

    state_t            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_a;
    logic [DATA_W-1:0] r_dd;
    logic              r_wr;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;

    req_t              w_in;
    req_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_in      = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign req_ready = !w_full;
    assign w_push    = req_valid && !w_full;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;
    assign busy      = !w_empty || (r_state != ST_IDLE);

    ram_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (w_in),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Bus sequencer. Every bus output is a flop so the strobe cannot glitch;
    // the async reset clears wr immediately, so an interrupted STROBE never
    // produces a second rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_a         <= '0;
            r_dd        <= '0;
            r_wr        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_wr        <= 1'b0;
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_a     <= w_head.addr;
                        r_dd    <= w_head.wdata;
                        r_we    <= w_head.we;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (r_we) begin
                        r_wr    <= 1'b1;
                        r_state <= ST_STROBE;
                    end else begin
                        // A has been stable a full cycle; D is settled.
                        r_rsp_data  <= D;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_STROBE: r_state <= ST_HOLD;
                ST_HOLD:   r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign A         = r_a;
    assign Dd        = r_dd;
    assign wr        = r_wr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: doc/ram_bus_ctrl.md
RAM_BUS_CTRL -- requirements
Module: ram_bus_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, request queue depth in entries; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  requester presents a RAM access.
REQ-005 req_ready  output  1  queue can accept; transfer occurs when req_valid && req_ready at a rising edge.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  8  byte address 00..FF, including port bytes FC..FF.
REQ-008 req_wdata  input  8  write data; ignored for reads.
REQ-009 rsp_valid  output  1  one-cycle pulse, rsp_data valid.
REQ-010 rsp_data  output  8  read result.
REQ-011 A  output  8  RAM address bus.
REQ-012 Dd  output  8  RAM write-data bus.
REQ-013 wr  output  1  RAM write strobe; RAM captures Dd at A on its rising edge.
REQ-014 D  input  8  RAM combinational read data for A.
REQ-015 busy  output  1  queue non-empty or FSM not IDLE.

Function
REQ-016 Queue SHALL be FIFO of {we, addr, wdata}; req_ready = not full; push while full is not possible, even if a pop occurs the same cycle.
REQ-017 Requests SHALL execute strictly in acceptance order; one access on the RAM bus at a time.
REQ-018 FSM states IDLE, ADDR, STROBE, HOLD; IDLE with queue non-empty pops head and goes to ADDR next cycle.
REQ-019 ADDR: A and Dd registered from popped entry, wr = 0; write -> STROBE, read -> IDLE with D sampled into rsp_data at the ADDR-exit edge.
REQ-020 STROBE: wr = 1, A/Dd unchanged; always -> HOLD.
REQ-021 HOLD: wr = 0, A/Dd unchanged; always -> IDLE.
REQ-022 rsp_valid SHALL be 1 exactly in the cycle after ADDR of a read, independent of next FSM state; no backpressure on response.
REQ-023 Latency from acceptance edge into empty, idle block: A valid after 1 edge; write wr high cycle 2, low cycle 3; read rsp_valid high cycle 2.
REQ-024 Throughput: write 4 cycles (IDLE, ADDR, STROBE, HOLD), read 2 cycles (IDLE, ADDR).
REQ-025 wr, A, Dd, rsp_valid, rsp_data SHALL be driven directly from flops (glitch-free strobe).
REQ-026 A and Dd SHALL hold last driven values in IDLE; wr SHALL be 1 only in STROBE.
REQ-027 Read issued after write to same address SHALL return the written value (guaranteed by serialization).
REQ-028 Port addresses FC..FF SHALL be treated as ordinary addresses.
REQ-029 Push and pop in same cycle SHALL be supported when not full; count unchanged.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 While rst_n = 0: queue empty, FSM IDLE, wr = 0, A = 00, Dd = 00, rsp_valid = 0, rsp_data = 00, req_ready = 1, busy = 0.
REQ-032 Reset mid-operation SHALL drop wr immediately (asynchronously) and discard queued and in-flight requests; no response is produced for a discarded read.
REQ-033 Reset during STROBE: write already captured by RAM stands; no second rising edge of wr is generated.

Structure
REQ-034 Shared package SHALL hold FSM state encoding and the request-entry record type (we, addr, wdata widths).
REQ-035 The queue SHALL be sub-module ram_req_fifo (parameterized depth and width, push/pop/full/empty); ram_bus_ctrl holds the FSM.

Verification
REQ-036 Single write addr 10 data 5A to idle block -> A=10, Dd=5A at cycle 1; wr=1 only cycle 2; RAM[10]=5A.
REQ-037 Write FF<-C3 then read FF back-to-back -> PORTA=C3; rsp_valid pulse with rsp_data=C3; total 6 cycles to response.
REQ-038 Push 4 requests with no pops possible before full (4 writes, depth 4) -> req_ready=0 after 4th, 5th held until a pop; all 5 executed in order.
REQ-039 Reads of 20,21,22 streamed -> three rsp_valid pulses every 2 cycles with RAM contents in order.
REQ-040 Assert rst_n=0 during STROBE with 2 requests queued -> wr falls immediately, busy=0, no responses, queue empty after release.
REQ-041 Wrap check: 10 alternating writes/reads through depth-4 FIFO -> every read returns the preceding write's data.
